// File: rtl/d_stage_ctrl_pkg.sv
// Shared decode-stage definitions: immediate-select codes, RV32I opcodes, FSM states.
// No logic; constants only.
// Imm-select codes match the immediate generator's encoding.
package d_stage_ctrl_pkg;

  // Immediate generator select codes (shared encoding with the imm generator)
  typedef enum logic [2:0] {
    IMM_S      = 3'd0,
    IMM_B      = 3'd1,
    IMM_U      = 3'd2,
    IMM_J      = 3'd3,
    IMM_I      = 3'd4,
    IMM_I_STAR = 3'd5
  } imm_sel_e;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  function automatic logic [4:0] rd_of(input logic [31:0] inst);
    return inst[11:7];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] inst);
    return inst[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] inst);
    return inst[24:20];
  endfunction

endpackage

// File: rtl/d_stage_ctrl_if.sv
// Fetch->decode->execute handshake bundle for the decode stage.
// Latency: none (wires only).
// Backpressure: f_ready from decode, x_ready from execute.
// Ports: f_valid/f_inst/f_pc/f_ready (fetch side), x_* (issue side), flush (redirect).
interface d_stage_ctrl_if;
  logic        f_valid;
  logic [31:0] f_inst;
  logic [31:0] f_pc;
  logic        f_ready;
  logic        x_valid;
  logic        x_ready;
  logic [31:0] x_inst;
  logic [31:0] x_pc;
  logic [2:0]  x_imm_sel;
  logic        x_rs1_used;
  logic        x_rs2_used;
  logic        x_illegal;
  logic        flush;

  // Decode stage side
  modport slave (
    input  f_valid, f_inst, f_pc, x_ready, flush,
    output f_ready, x_valid, x_inst, x_pc, x_imm_sel, x_rs1_used, x_rs2_used, x_illegal
  );

  // Surrounding pipeline side (fetch + execute)
  modport master (
    output f_valid, f_inst, f_pc, x_ready, flush,
    input  f_ready, x_valid, x_inst, x_pc, x_imm_sel, x_rs1_used, x_rs2_used, x_illegal
  );
endinterface

// File: rtl/d_stage_decode.sv
// Instruction field decode: opcode/funct3 -> imm_sel, rs1_used, rs2_used, illegal.
// Latency: combinational.
// Backpressure: none.
// Ports: opcode[6:0], funct3[2:0] in; imm_sel, rs1_used, rs2_used, illegal out.
module d_stage_decode
  import d_stage_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output imm_sel_e   imm_sel,
  output logic       rs1_used,
  output logic       rs2_used,
  output logic       illegal
);

  always_comb begin
    imm_sel  = IMM_I;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        rs1_used = 1'b1;
        // shift-immediates carry shamt/funct7 in the upper immediate bits
        if (funct3 == 3'b001 || funct3 == 3'b101) imm_sel = IMM_I_STAR;
      end
      OPC_LOAD, OPC_JALR: rs1_used = 1'b1;
      // CSRRW/CSRRS/CSRRC read rs1; the *I forms and ECALL/EBREAK do not
      OPC_SYSTEM: rs1_used = !funct3[2] && (funct3 != 3'b000);
      OPC_STORE: begin
        imm_sel  = IMM_S;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_BRANCH: begin
        imm_sel  = IMM_B;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: imm_sel = IMM_U;
      OPC_JAL: imm_sel = IMM_J;
      OPC_OP: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/d_stage_ctrl.sv
// Decode-stage sequencer: one-entry decode register, load-use bubble insertion, flush kill.
// Latency: 1 cycle fetch->issue; x_* are combinational from the decode register.
// Backpressure: f_ready follows issue (combinational on x_ready); x_valid never depends on x_ready.
// Ports: clk, rst_n (async, active low); dif (slave) carries fetch, issue and flush signals.
module d_stage_ctrl
  import d_stage_ctrl_pkg::*;
#(
  parameter int unsigned  LOAD_USE_BUBBLES = 1,
  parameter logic [31:0]  NOP_INST         = NOP_INST_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  d_stage_ctrl_if.slave  dif
);

  localparam logic [1:0] BUBBLES = 2'(LOAD_USE_BUBBLES);

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        mk_vld_q, mk_vld_d;
  logic [4:0]  mk_rd_q, mk_rd_d;
  logic [1:0]  cnt_q, cnt_d;

  logic [31:0] cur_inst;
  imm_sel_e    imm_sel;
  logic        rs1_used, rs2_used, illegal;
  logic        hazard;
  logic        x_valid, f_ready;

  assign cur_inst = (state_q == ST_EMPTY) ? NOP_INST : inst_q;

  d_stage_decode u_decode (
    .opcode   (cur_inst[6:0]),
    .funct3   (cur_inst[14:12]),
    .imm_sel  (imm_sel),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .illegal  (illegal)
  );

  assign hazard = mk_vld_q && (mk_rd_q != 5'd0) &&
                  ((rs1_used && rs1_of(cur_inst) == mk_rd_q) ||
                   (rs2_used && rs2_of(cur_inst) == mk_rd_q));

  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    mk_vld_d = mk_vld_q;
    mk_rd_d  = mk_rd_q;
    cnt_d    = cnt_q;
    x_valid  = 1'b0;
    f_ready  = 1'b0;

    if (dif.flush) begin
      state_d  = ST_EMPTY;
      mk_vld_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          f_ready = 1'b1;
          if (dif.f_valid) state_d = ST_FULL;
        end
        ST_FULL: begin
          x_valid = !hazard;
          if (!hazard) begin
            if (dif.x_ready) begin
              f_ready  = 1'b1;
              // marker tracks only the instruction issued last
              mk_vld_d = (inst_q[6:0] == OPC_LOAD);
              mk_rd_d  = rd_of(inst_q);
              state_d  = dif.f_valid ? ST_FULL : ST_EMPTY;
            end
          end else if (dif.x_ready) begin
            // the hazard-detect cycle is itself the first bubble seen by execute
            if (BUBBLES == 2'd1) begin
              mk_vld_d = 1'b0;
            end else begin
              state_d = ST_STALL;
              cnt_d   = BUBBLES - 2'd1;
            end
          end else begin
            state_d = ST_STALL;
            cnt_d   = BUBBLES;
          end
        end
        ST_STALL: begin
          // bubbles only count when execute could have consumed an instruction
          if (dif.x_ready) begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
              mk_vld_d = 1'b0;
              state_d  = ST_FULL;
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    if (f_ready && dif.f_valid) begin
      inst_d = dif.f_inst;
      pc_d   = dif.f_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      inst_q   <= NOP_INST;
      pc_q     <= 32'd0;
      mk_vld_q <= 1'b0;
      mk_rd_q  <= 5'd0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      mk_vld_q <= mk_vld_d;
      mk_rd_q  <= mk_rd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dif.f_ready    = f_ready;
  assign dif.x_valid    = x_valid;
  assign dif.x_inst     = cur_inst;
  assign dif.x_pc       = pc_q;
  assign dif.x_imm_sel  = imm_sel;
  assign dif.x_rs1_used = rs1_used;
  assign dif.x_rs2_used = rs2_used;
  assign dif.x_illegal  = illegal;

endmodule
